// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker and its reference model.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        F_AND  = 3'd0,
        F_OR   = 3'd1,
        F_XOR  = 3'd2,
        F_NAND = 3'd3,
        F_NOR  = 3'd4,
        F_XNOR = 3'd5
    } gate_func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    localparam logic [2:0] FUNC_MAX = 3'd5;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model: reduces every bit of vec through the selected gate function.
module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      func,
    input  logic [N_IN-1:0] vec,
    output logic            exp_y
);

    always_comb begin
        exp_y = 1'b0;
        case (gate_func_t'(func))
            F_AND:   exp_y = &vec;
            F_OR:    exp_y = |vec;
            F_XOR:   exp_y = ^vec;
            F_NAND:  exp_y = ~&vec;
            F_NOR:   exp_y = ~|vec;
            F_XNOR:  exp_y = ~^vec;
            default: exp_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps every input vector into a gate under test, samples its settled output and
// logs mismatches against the reference model (saturating count plus first failing vector).
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic             dut_y,
    output logic [N_IN-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam logic [7:0]      SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    chk_state_t       state, state_nxt;
    gate_func_t       func_q, func_nxt;
    logic [7:0]       settle_cnt, settle_nxt;
    logic [N_IN-1:0]  vec_q, vec_nxt;
    logic [CNT_W-1:0] err_q, err_nxt;
    logic             ffv_q, ffv_nxt;
    logic [N_IN-1:0]  ffvec_q, ffvec_nxt;
    logic             exp_y;
    logic             start_ok;
    logic             sample;
    logic             mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    gate_ref_model #(
        .N_IN (N_IN)
    ) u_ref (
        .func  (func_q),
        .vec   (vec_q),
        .exp_y (exp_y)
    );

    assign start_ok = start && (func <= FUNC_MAX);
    // dut_y is only trusted on the edge that closes the last settle cycle of a vector
    assign sample   = (state == RUN) && (settle_cnt == 8'd0);
    assign mismatch = sample && (dut_y != exp_y);

    always_comb begin
        state_nxt  = state;
        func_nxt   = func_q;
        settle_nxt = settle_cnt;
        vec_nxt    = vec_q;
        err_nxt    = err_q;
        ffv_nxt    = ffv_q;
        ffvec_nxt  = ffvec_q;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_nxt  = RUN;
                    func_nxt   = gate_func_t'(func);
                    settle_nxt = SETTLE_LD;
                    vec_nxt    = '0;
                    err_nxt    = '0;
                    ffv_nxt    = 1'b0;
                    ffvec_nxt  = '0;
                end
            end
            RUN: begin
                if (!sample) begin
                    settle_nxt = settle_cnt - 8'd1;
                end else begin
                    if (mismatch) begin
                        err_nxt = sat_inc(err_q);
                        if (!ffv_q) begin
                            ffv_nxt   = 1'b1;
                            ffvec_nxt = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        vec_nxt    = vec_q + N_IN'(1);
                        settle_nxt = SETTLE_LD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            func_q     <= F_AND;
            settle_cnt <= '0;
            vec_q      <= '0;
            err_q      <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
        end else begin
            state      <= state_nxt;
            func_q     <= func_nxt;
            settle_cnt <= settle_nxt;
            vec_q      <= vec_nxt;
            err_q      <= err_nxt;
            ffv_q      <= ffv_nxt;
            ffvec_q    <= ffvec_nxt;
        end
    end

    assign dut_in           = vec_q;
    assign busy             = (state == RUN);
    assign done             = (state == DONE);
    assign pass             = done && (err_q == '0);
    assign err_cnt          = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule
